// File: rtl/dma_pkg.sv
// dma_pkg: shared types and helpers for the DMA write-burst engine.
// Holds the controller state encoding and the burst-length arithmetic, so that
// the command and data paths cut bursts in exactly the same places.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dma_state_e;

    // Beats in the next burst: the smallest of what is left, the burst cap and
    // the room before the next split boundary.
    function automatic logic [31:0] burst_beats(input logic [31:0] remaining,
                                                input logic [31:0] max_beats,
                                                input logic [31:0] boundary_beats);
        logic [31:0] n;
        n = remaining;
        if (max_beats < n) n = max_beats;
        if (boundary_beats < n) n = boundary_beats;
        return n;
    endfunction

    // Beats left before the next 4 KB boundary, given the in-page byte offset.
    function automatic logic [31:0] page_room_beats(input logic [11:0] offset,
                                                    input int lsb);
        logic [12:0] room;
        room = 13'h1000 - {1'b0, offset};
        return 32'(room >> lsb);
    endfunction

endpackage

// File: rtl/sfifo.sv
// sfifo: single-clock FIFO, 2**AW entries, synchronous active-low reset.
// SHOW_AHEAD=1 presents the head entry combinationally on dout_o; otherwise
// dout_o is registered on pop.
module sfifo #(
    parameter int DW         = 32,
    parameter int AW         = 4,
    parameter bit SHOW_AHEAD = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o
);
    localparam int        DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;

    // Storage array; contents need no reset since count_q gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    if (SHOW_AHEAD) begin : g_show_ahead
        assign dout_o = mem_q[rd_ptr_q];
    end else begin : g_registered
        logic [DW-1:0] dout_q;
        // Registered read port, updated only when an entry is consumed.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) dout_q <= '0;
            else if (do_pop) dout_q <= mem_q[rd_ptr_q];
        end
        assign dout_o = dout_q;
    end

endmodule

// File: rtl/dma_w_burst.sv
// dma_w_burst: reads a linear block from a wait-stated RAM and emits it as
// write bursts (one command per burst on dmaw_*, beats on dma_w*).
// Command and beat paths cut bursts independently with the same helper, so
// the command path can run ahead of the data. Strobe and wlast ride in the
// write FIFO next to the data.
// Build option: define DMA_W_4K_SPLIT_EN to also end bursts at 4 KB
// destination boundaries.
module dma_w_burst
    import dma_pkg::*;
#(
    parameter int AXI_DW    = 128,
    parameter int AXI_BYTES = AXI_DW / 8,
    parameter int RAM_WS    = 1,
    parameter int WFF_AW    = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 usr_clk,
    input  logic                 usr_reset_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [31:0]          cfg_src_sa,
    input  logic [31:0]          cfg_dst_sa,
    input  logic [31:0]          cfg_len,
    output logic                 dmaw_valid,
    input  logic                 dmaw_ready,
    output logic [31:0]          dmaw_sa,
    output logic [31:0]          dmaw_len,
    output logic [AXI_DW-1:0]    dma_wdata,
    output logic [AXI_BYTES-1:0] dma_wstrb,
    output logic                 dma_wlast,
    output logic                 dma_wvalid,
    input  logic                 dma_wready,
    output logic                 ram_re,
    output logic [31:0]          ram_a,
    input  logic [AXI_DW-1:0]    ram_q,
    output logic                 done,
    output logic                 busy
);
    localparam int          L        = $clog2(AXI_BYTES);
    localparam int          DEPTH    = 1 << WFF_AW;
    localparam int          CW       = WFF_AW + 2;
    localparam int          FW       = AXI_DW + AXI_BYTES + 1;
    localparam logic [31:0] BYTES32  = 32'(AXI_BYTES);
    localparam logic [31:0] LOW_MASK = BYTES32 - 32'd1;
    localparam logic [31:0] MAXB32   = 32'(MAX_BURST);

    dma_state_e     state_q;
    logic           done_q;
    logic [31:0]    wr_left_q;
    logic [31:0]    rd_addr_q;
    logic [31:0]    rd_left_q;
    logic [31:0]    rd_burst_q;
    logic [31:0]    rem_q;
    logic [31:0]    cmd_addr_q;
    logic [31:0]    cmd_left_q;
    logic           dmaw_valid_q;
    logic [31:0]    dmaw_sa_q;
    logic [31:0]    dmaw_len_q;
    logic [CW-1:0]  inflight_q;

    logic           start_w;
    logic [31:0]    beats_w;
    logic [31:0]    rd_bnd_w;
    logic [31:0]    cmd_bnd_w;
    logic [31:0]    rd_cur_w;
    logic [31:0]    cmd_beats_w;
    logic [31:0]    cmd_bytes_w;
    logic           cmd_load_w;
    logic           ram_re_w;
    logic [CW-1:0]  occ_w;
    logic [AXI_BYTES-1:0] rem_mask_w;
    logic [AXI_BYTES-1:0] strb_now_w;
    logic [AXI_BYTES:0]   meta_now_w;
    logic [AXI_BYTES:0]   meta_w;
    logic           fifo_push_w;
    logic           fifo_pop_w;
    logic [FW-1:0]  fifo_dout_w;
    logic           fifo_empty_w;
    logic           fifo_full_w;
    logic [WFF_AW:0] fifo_count_w;

    assign start_w = (state_q == ST_IDLE) && cfg_valid && (cfg_len != 32'd0);
    assign beats_w = (cfg_len >> L) + 32'((cfg_len & LOW_MASK) != 32'd0);

`ifdef DMA_W_4K_SPLIT_EN
    logic [11:0] rd_dst_q;

    // Destination offset of the next beat to read, used only for page cuts.
    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) rd_dst_q <= '0;
        else if (start_w) rd_dst_q <= cfg_dst_sa[11:0] & ~LOW_MASK[11:0];
        else if (ram_re_w) rd_dst_q <= rd_dst_q + BYTES32[11:0];
    end

    assign rd_bnd_w  = page_room_beats(rd_dst_q, L);
    assign cmd_bnd_w = page_room_beats(cmd_addr_q[11:0], L);
`else
    assign rd_bnd_w  = MAXB32;
    assign cmd_bnd_w = MAXB32;
`endif

    // Strobe pattern of the final transfer beat; all-ones for whole beats.
    always_comb begin
        rem_mask_w = '0;
        for (int i = 0; i < AXI_BYTES; i++) begin
            rem_mask_w[i] = (rem_q == 32'd0) || (32'(i) < rem_q);
        end
    end

    // A read is allowed only if its beat is guaranteed a FIFO slot on arrival.
    assign occ_w    = CW'(fifo_count_w) + inflight_q;
    assign ram_re_w = (state_q == ST_RUN) && (rd_left_q != 32'd0) &&
                      !fifo_full_w && (occ_w < CW'(DEPTH));

    assign rd_cur_w   = (rd_burst_q == 32'd0) ? burst_beats(rd_left_q, MAXB32, rd_bnd_w)
                                              : rd_burst_q;
    assign strb_now_w = (rd_left_q == 32'd1) ? rem_mask_w : '1;
    assign meta_now_w = {(rd_cur_w == 32'd1), strb_now_w};

    // Read-side address, beat counters and residual byte count.
    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            rd_addr_q  <= '0;
            rd_left_q  <= '0;
            rd_burst_q <= '0;
            rem_q      <= '0;
        end else if (start_w) begin
            rd_addr_q  <= cfg_src_sa & ~LOW_MASK;
            rd_left_q  <= beats_w;
            rd_burst_q <= '0;
            rem_q      <= cfg_len & LOW_MASK;
        end else if (ram_re_w) begin
            rd_addr_q  <= rd_addr_q + BYTES32;
            rd_left_q  <= rd_left_q - 32'd1;
            rd_burst_q <= rd_cur_w - 32'd1;
        end
    end

    if (RAM_WS == 0) begin : g_ws0
        assign fifo_push_w = ram_re_w;
        assign meta_w      = meta_now_w;
    end else begin : g_ws
        logic [RAM_WS-1:0] pv_q;
        logic [AXI_BYTES:0] pm_q [RAM_WS];

        // Valid bits of reads in flight; cleared by reset so stale data is dropped.
        always_ff @(posedge usr_clk) begin
            if (!usr_reset_n) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= ram_re_w;
                for (int i = 1; i < RAM_WS; i++) pv_q[i] <= pv_q[i-1];
            end
        end

        // Strobe/wlast of each in-flight read, aligned with its RAM latency.
        always_ff @(posedge usr_clk) begin
            pm_q[0] <= meta_now_w;
            for (int i = 1; i < RAM_WS; i++) pm_q[i] <= pm_q[i-1];
        end

        assign fifo_push_w = pv_q[RAM_WS-1];
        assign meta_w      = pm_q[RAM_WS-1];
    end

    // Reads issued but not yet written into the FIFO.
    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) inflight_q <= '0;
        else inflight_q <= inflight_q + CW'(ram_re_w) - CW'(fifo_push_w);
    end

    sfifo #(
        .DW         (FW),
        .AW         (WFF_AW),
        .SHOW_AHEAD (1'b1)
    ) u_wff (
        .clk_i   (usr_clk),
        .rst_ni  (usr_reset_n),
        .push_i  (fifo_push_w),
        .din_i   ({meta_w, ram_q}),
        .pop_i   (fifo_pop_w),
        .dout_o  (fifo_dout_w),
        .empty_o (fifo_empty_w),
        .full_o  (fifo_full_w),
        .count_o (fifo_count_w)
    );

    assign fifo_pop_w = !fifo_empty_w && dma_wready;

    assign cmd_beats_w = burst_beats(cmd_left_q, MAXB32, cmd_bnd_w);
    assign cmd_bytes_w = ((cmd_beats_w == cmd_left_q) && (rem_q != 32'd0))
                         ? (((cmd_beats_w - 32'd1) << L) + rem_q)
                         : (cmd_beats_w << L);
    assign cmd_load_w  = (state_q != ST_IDLE) && (cmd_left_q != 32'd0) &&
                         (!dmaw_valid_q || dmaw_ready);

    // Command channel: next burst is loaded as soon as the slot frees up.
    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            cmd_addr_q   <= '0;
            cmd_left_q   <= '0;
            dmaw_valid_q <= 1'b0;
            dmaw_sa_q    <= '0;
            dmaw_len_q   <= '0;
        end else if (start_w) begin
            cmd_addr_q <= cfg_dst_sa & ~LOW_MASK;
            cmd_left_q <= beats_w;
        end else if (cmd_load_w) begin
            dmaw_valid_q <= 1'b1;
            dmaw_sa_q    <= cmd_addr_q;
            dmaw_len_q   <= cmd_bytes_w;
            cmd_addr_q   <= cmd_addr_q + (cmd_beats_w << L);
            cmd_left_q   <= cmd_left_q - cmd_beats_w;
        end else if (dmaw_valid_q && dmaw_ready) begin
            dmaw_valid_q <= 1'b0;
        end
    end

    // Controller FSM with registered done pulse and outstanding-beat count.
    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            wr_left_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (fifo_pop_w) wr_left_q <= wr_left_q - 32'd1;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_len == 32'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q   <= ST_RUN;
                            wr_left_q <= beats_w;
                        end
                    end
                end
                ST_RUN: begin
                    if (ram_re_w && (rd_left_q == 32'd1)) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_pop_w && (wr_left_q == 32'd1)) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign ram_re     = ram_re_w;
    assign ram_a      = rd_addr_q;
    assign dmaw_valid = dmaw_valid_q;
    assign dmaw_sa    = dmaw_sa_q;
    assign dmaw_len   = dmaw_len_q;
    assign dma_wvalid = !fifo_empty_w;
    assign dma_wdata  = fifo_dout_w[AXI_DW-1:0];
    assign dma_wstrb  = fifo_dout_w[AXI_DW +: AXI_BYTES];
    assign dma_wlast  = fifo_dout_w[FW-1] && !fifo_empty_w;

endmodule

// File: tb/tb_dma_w_burst.sv
// tb_dma_w_burst: directed bench for dma_w_burst (128-bit bus, RAM_WS=2).
// Expected commands, beat counts, wlast positions and strobes are hand-computed;
// beat data comes from the bench's own RAM content function.
module tb_dma_w_burst;
    import dma_pkg::*;

    localparam int DW = 128;
    localparam int NB = 16;

    logic            usr_clk = 1'b0;
    logic            usr_reset_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [31:0]     cfg_src_sa;
    logic [31:0]     cfg_dst_sa;
    logic [31:0]     cfg_len;
    logic            dmaw_valid;
    logic            dmaw_ready;
    logic [31:0]     dmaw_sa;
    logic [31:0]     dmaw_len;
    logic [DW-1:0]   dma_wdata;
    logic [NB-1:0]   dma_wstrb;
    logic            dma_wlast;
    logic            dma_wvalid;
    logic            dma_wready;
    logic            ram_re;
    logic [31:0]     ram_a;
    logic [DW-1:0]   ram_q;
    logic            done;
    logic            busy;

    always #5 usr_clk = ~usr_clk;

    dma_w_burst #(
        .AXI_DW    (DW),
        .RAM_WS    (2),
        .WFF_AW    (4),
        .MAX_BURST (16)
    ) dut (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_src_sa  (cfg_src_sa),
        .cfg_dst_sa  (cfg_dst_sa),
        .cfg_len     (cfg_len),
        .dmaw_valid  (dmaw_valid),
        .dmaw_ready  (dmaw_ready),
        .dmaw_sa     (dmaw_sa),
        .dmaw_len    (dmaw_len),
        .dma_wdata   (dma_wdata),
        .dma_wstrb   (dma_wstrb),
        .dma_wlast   (dma_wlast),
        .dma_wvalid  (dma_wvalid),
        .dma_wready  (dma_wready),
        .ram_re      (ram_re),
        .ram_a       (ram_a),
        .ram_q       (ram_q),
        .done        (done),
        .busy        (busy)
    );

    function automatic logic [127:0] ram_word(input logic [31:0] a);
        return {~a, a + 32'd1, a ^ 32'h5A5A5A5A, a};
    endfunction

    // RAM with two wait states: data for the address presented with ram_re
    // appears two cycles later.
    logic [31:0] ra0_q, ra1_q;
    always @(posedge usr_clk) begin
        ra0_q <= ram_a;
        ra1_q <= ra0_q;
    end
    assign ram_q = ram_word(ra1_q);

    // Monitor: record handshakes away from the active edge.
    int cyc = 0;
    int re_cnt = 0, done_cnt = 0, done_cyc = -1, cmdv_cnt = 0;
    logic [31:0]  mc_sa[$];
    logic [31:0]  mc_len[$];
    logic [127:0] mb_data[$];
    logic [15:0]  mb_strb[$];
    logic         mb_last[$];

    always @(posedge usr_clk) cyc <= cyc + 1;

    always @(negedge usr_clk) begin
        if (usr_reset_n) begin
            if (dmaw_valid && dmaw_ready) begin
                mc_sa.push_back(dmaw_sa);
                mc_len.push_back(dmaw_len);
            end
            if (dma_wvalid && dma_wready) begin
                mb_data.push_back(dma_wdata);
                mb_strb.push_back(dma_wstrb);
                mb_last.push_back(dma_wlast);
            end
            if (ram_re) re_cnt <= re_cnt + 1;
            if (dmaw_valid) cmdv_cnt <= cmdv_cnt + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int b_cmd, b_beat, b_re, b_done, b_cmdv, acc_cyc;
    logic [31:0] exp_sa[4];
    logic [31:0] exp_len[4];

    task automatic snapshot();
        b_cmd  = mc_sa.size();
        b_beat = mb_data.size();
        b_re   = re_cnt;
        b_done = done_cnt;
        b_cmdv = cmdv_cnt;
    endtask

    task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        chk("cfg_ready_idle", 128'(cfg_ready), 128'(1));
        snapshot();
        cfg_src_sa = s;
        cfg_dst_sa = d;
        cfg_len    = l;
        cfg_valid  = 1'b1;
        @(posedge usr_clk);
        #1;
        acc_cyc   = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while (done_cnt == b_done && k < lim) begin
            @(posedge usr_clk);
            k++;
        end
        chk("done_seen", 128'(done_cnt > b_done), 128'(1));
        repeat (3) @(posedge usr_clk);
        #1;
    endtask

    task automatic check_xfer(input string nm, input logic [31:0] src, input int ncmd,
                              input int nbeat, input logic [63:0] lmask,
                              input logic [15:0] lstrb);
        int nc, nbt;
        logic [31:0] sa;
        nc  = mc_sa.size() - b_cmd;
        nbt = mb_data.size() - b_beat;
        sa  = src & ~32'hF;
        chk({nm, "_ncmd"}, 128'(nc), 128'(ncmd));
        for (int i = 0; i < ncmd && i < nc; i++) begin
            chk($sformatf("%s_cmd%0d_sa", nm, i), 128'(mc_sa[b_cmd+i]), 128'(exp_sa[i]));
            chk($sformatf("%s_cmd%0d_len", nm, i), 128'(mc_len[b_cmd+i]), 128'(exp_len[i]));
        end
        chk({nm, "_nbeats"}, 128'(nbt), 128'(nbeat));
        for (int i = 0; i < nbeat && i < nbt; i++) begin
            chk($sformatf("%s_data%0d", nm, i), mb_data[b_beat+i], ram_word(sa + 32'(i) * 32'd16));
            chk($sformatf("%s_strb%0d", nm, i), 128'(mb_strb[b_beat+i]),
                128'((i == nbeat - 1) ? lstrb : 16'hFFFF));
            chk($sformatf("%s_last%0d", nm, i), 128'(mb_last[b_beat+i]), 128'(lmask[i]));
        end
        chk({nm, "_ram_re"}, 128'(re_cnt - b_re), 128'(nbeat));
        chk({nm, "_done_cnt"}, 128'(done_cnt - b_done), 128'(1));
        chk({nm, "_busy_after"}, 128'(busy), 128'(0));
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_cfg_ready"}, 128'(cfg_ready), 128'(1));
        chk({nm, "_dmaw_valid"}, 128'(dmaw_valid), 128'(0));
        chk({nm, "_dma_wvalid"}, 128'(dma_wvalid), 128'(0));
        chk({nm, "_dma_wlast"}, 128'(dma_wlast), 128'(0));
        chk({nm, "_ram_re"}, 128'(ram_re), 128'(0));
        chk({nm, "_done"}, 128'(done), 128'(0));
        chk({nm, "_busy"}, 128'(busy), 128'(0));
        chk({nm, "_ram_a"}, 128'(ram_a), 128'(0));
        chk({nm, "_dmaw_sa"}, 128'(dmaw_sa), 128'(0));
        chk({nm, "_dmaw_len"}, 128'(dmaw_len), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, r0;
        usr_reset_n = 1'b0;
        cfg_valid   = 1'b0;
        cfg_src_sa  = '0;
        cfg_dst_sa  = '0;
        cfg_len     = '0;
        dmaw_ready  = 1'b1;
        dma_wready  = 1'b1;
        repeat (3) @(posedge usr_clk);
        #1;
        check_reset_outputs("por");
        usr_reset_n = 1'b1;
        @(posedge usr_clk);
        #1;

        // 512 bytes to 0x1000: two full 256-byte bursts.
        start(32'h0, 32'h1000, 32'd512);
        chk("t1_busy", 128'(busy), 128'(1));
        wait_done(500);
        exp_sa[0] = 32'h1000; exp_len[0] = 32'd256;
        exp_sa[1] = 32'h1100; exp_len[1] = 32'd256;
        check_xfer("t1", 32'h0, 2, 32, 64'h0000_0000_8000_8000, 16'hFFFF);

        // 40 bytes, unaligned addresses: one 40-byte burst, partial last strobe.
        start(32'h30F, 32'h200B, 32'd40);
        wait_done(200);
        exp_sa[0] = 32'h2000; exp_len[0] = 32'd40;
        check_xfer("t2", 32'h300, 1, 3, 64'h4, 16'h00FF);

        // Zero length: done on the cycle after acceptance, nothing else.
        start(32'h123, 32'h456, 32'd0);
        chk("t3_done_now", 128'(done), 128'(1));
        chk("t3_busy", 128'(busy), 128'(0));
        @(posedge usr_clk);
        #1;
        chk("t3_done_pulse", 128'(done), 128'(0));
        repeat (5) @(posedge usr_clk);
        #1;
        chk("t3_done_cyc", 128'(done_cyc - acc_cyc), 128'(0));
        chk("t3_done_cnt", 128'(done_cnt - b_done), 128'(1));
        chk("t3_cmdv", 128'(cmdv_cnt - b_cmdv), 128'(0));
        chk("t3_ram_re", 128'(re_cnt - b_re), 128'(0));
        chk("t3_beats", 128'(mb_data.size() - b_beat), 128'(0));

        // 1024 bytes with a 50-cycle write stall mid-burst.
        start(32'h100, 32'h4000, 32'd1024);
        k = 0;
        while ((mb_data.size() - b_beat) < 5 && k < 300) begin
            @(posedge usr_clk);
            k++;
        end
        chk("t4_reach_stall", 128'((mb_data.size() - b_beat) >= 5), 128'(1));
        #1;
        dma_wready = 1'b0;
        repeat (20) @(posedge usr_clk);
        r0 = re_cnt;
        repeat (30) @(posedge usr_clk);
        #1;
        chk("t4_stall_no_re", 128'(re_cnt - r0), 128'(0));
        chk("t4_stall_wvalid", 128'(dma_wvalid), 128'(1));
        dma_wready = 1'b1;
        wait_done(500);
        exp_sa[0] = 32'h4000; exp_len[0] = 32'd256;
        exp_sa[1] = 32'h4100; exp_len[1] = 32'd256;
        exp_sa[2] = 32'h4200; exp_len[2] = 32'd256;
        exp_sa[3] = 32'h4300; exp_len[3] = 32'd256;
        check_xfer("t4", 32'h100, 4, 64, 64'h8000_8000_8000_8000, 16'hFFFF);

        // 256 bytes to 0xF80, straddling a 4 KB page.
        start(32'h200, 32'hF80, 32'd256);
        wait_done(300);
`ifdef DMA_W_4K_SPLIT_EN
        exp_sa[0] = 32'hF80;  exp_len[0] = 32'd128;
        exp_sa[1] = 32'h1000; exp_len[1] = 32'd128;
        check_xfer("t5", 32'h200, 2, 16, 64'h8080, 16'hFFFF);
`else
        exp_sa[0] = 32'hF80;  exp_len[0] = 32'd256;
        check_xfer("t5", 32'h200, 1, 16, 64'h8000, 16'hFFFF);
`endif

        // Reset in the middle of a transfer, then a clean 64-byte transfer.
        start(32'h0, 32'h5000, 32'd1024);
        repeat (10) @(posedge usr_clk);
        #1;
        chk("t6_busy_pre", 128'(busy), 128'(1));
        usr_reset_n = 1'b0;
        @(posedge usr_clk);
        #1;
        check_reset_outputs("t6_rst");
        usr_reset_n = 1'b1;
        @(posedge usr_clk);
        #1;
        start(32'h40, 32'h6000, 32'd64);
        wait_done(200);
        exp_sa[0] = 32'h6000; exp_len[0] = 32'd64;
        check_xfer("t6", 32'h40, 1, 4, 64'h8, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
